// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand sequencer: default widths, sequencer
// state encoding and the accumulator sizing helper.
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 24;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } seq_state_e;

  // Bits needed to hold vec_len * (2^data_w - 1)^2 without wrapping.
  function automatic int unsigned acc_width_required(input int unsigned data_w,
                                                     input int unsigned vec_len);
    longint unsigned op_max;
    longint unsigned sum_max;
    int unsigned     width;
    op_max  = (64'd1 << data_w) - 64'd1;
    sum_max = 64'(vec_len) * op_max * op_max;
    width   = 0;
    while (sum_max != 64'd0) begin
      width   = width + 1;
      sum_max = sum_max >> 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Operand stream, MAC drive and result port of one processing element.
interface mac_operand_sequencer_if
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_en;
  logic              mac_clear;
  logic [ACC_W-1:0]  mac_out;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              busy;

  modport slave (
    input  s_valid, s_a, s_b, mac_out, res_ready,
    output s_ready, mac_a, mac_b, mac_en, mac_clear, res_valid, res_data, busy
  );

  modport master (
    output s_valid, s_a, s_b, mac_out, res_ready,
    input  s_ready, mac_a, mac_b, mac_en, mac_clear, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac.sv
// Single-cycle multiply-accumulate: acc reflects a*b one cycle after en.
module mac
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [ACC_W-1:0] acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ACC_W'(a) * ACC_W'(b);
    end
  end

  assign acc = acc_reg;
endmodule

// File: rtl/mac_operand_sequencer.sv
// Groups an (a, b) operand stream into VEC_LEN-pair dot products on the MAC
// and hands each drained sum out on a valid/ready result port.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  mac_operand_sequencer_if.slave   bus
);
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 1) + 1;
  localparam logic [CNT_W-1:0]   LAST_PAIR  = CNT_W'(VEC_LEN - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(MAC_LAT);

  if (VEC_LEN < 1 || VEC_LEN > 65535) begin : g_bad_vec_len
    $fatal(1, "mac_operand_sequencer: VEC_LEN out of range 1..65535");
  end
  if (acc_width_required(DATA_W, VEC_LEN) > ACC_W) begin : g_bad_acc_w
    $fatal(1, "mac_operand_sequencer: ACC_W too narrow for VEC_LEN full-scale products");
  end

  seq_state_e         state_reg;
  seq_state_e         state_next;
  logic [CNT_W-1:0]   pair_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic [DATA_W-1:0]  mac_a_reg;
  logic [DATA_W-1:0]  mac_b_reg;
  logic               mac_en_reg;
  logic [ACC_W-1:0]   res_data_reg;
  logic               handshake;
  logic               last_pair;
  logic               drain_done;

  assign handshake  = bus.s_valid && (state_reg == ACCUM);
  assign last_pair  = (pair_cnt_reg == LAST_PAIR);
  assign drain_done = (drain_cnt_reg == LAST_DRAIN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:   state_next = ACCUM;
      ACCUM:   if (handshake && last_pair) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= CLEAR;
      pair_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      mac_a_reg     <= '0;
      mac_b_reg     <= '0;
      mac_en_reg    <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mac_en_reg <= handshake;
      if (handshake) begin
        mac_a_reg    <= bus.s_a;
        mac_b_reg    <= bus.s_b;
        pair_cnt_reg <= last_pair ? '0 : pair_cnt_reg + CNT_W'(1);
      end
      // Drain count starts with the cycle carrying the final mac_en.
      if (state_reg == DRAIN) begin
        if (drain_done) begin
          drain_cnt_reg <= '0;
          res_data_reg  <= bus.mac_out;
        end else begin
          drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
        end
      end
    end
  end

  // Gated by reset so the MAC sees no clear pulse while reset is held.
  assign bus.mac_clear = (state_reg == CLEAR) && reset;
  assign bus.s_ready   = (state_reg == ACCUM);
  assign bus.res_valid = (state_reg == RESULT);
  assign bus.busy      = (state_reg != CLEAR);
  assign bus.mac_a     = mac_a_reg;
  assign bus.mac_b     = mac_b_reg;
  assign bus.mac_en    = mac_en_reg;
  assign bus.res_data  = res_data_reg;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench: three sequencer+mac pairs (VEC_LEN 4, 16, 1) driven from vector tables,
// hand-written timing sequences and random vectors against a sum-of-products model.
module tb_mac_operand_sequencer;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          s_valid   [NI];
  logic [DW-1:0] s_a       [NI];
  logic [DW-1:0] s_b       [NI];
  logic          res_ready [NI];
  logic          s_ready   [NI];
  logic          mac_en    [NI];
  logic          mac_clear [NI];
  logic          res_valid [NI];
  logic          busy      [NI];
  logic [DW-1:0] mac_a     [NI];
  logic [DW-1:0] mac_b     [NI];
  logic [AW-1:0] res_data  [NI];
  logic [AW-1:0] mac_out   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_pe
    localparam int unsigned VL = (gi == 0) ? 4 : (gi == 1) ? 16 : 1;
    mac_operand_sequencer_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
    assign bus.s_valid   = s_valid[gi];
    assign bus.s_a       = s_a[gi];
    assign bus.s_b       = s_b[gi];
    assign bus.res_ready = res_ready[gi];
    assign bus.mac_out   = mac_out[gi];
    assign s_ready[gi]   = bus.s_ready;
    assign mac_en[gi]    = bus.mac_en;
    assign mac_clear[gi] = bus.mac_clear;
    assign res_valid[gi] = bus.res_valid;
    assign busy[gi]      = bus.busy;
    assign mac_a[gi]     = bus.mac_a;
    assign mac_b[gi]     = bus.mac_b;
    assign res_data[gi]  = bus.res_data;

    mac_operand_sequencer #(.DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL), .MAC_LAT(1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    mac #(.DATA_W(DW), .ACC_W(AW)) u_mac (
      .clk   (clk),
      .rst_n (reset),
      .clear (bus.mac_clear),
      .en    (bus.mac_en),
      .a     (bus.mac_a),
      .b     (bus.mac_b),
      .acc   (mac_out[gi])
    );
  end

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              bubble;
    int              hold;
    logic [63:0]     exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Every cycle advance goes through here so clear/en overlap is watched throughout.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("pe%0d_clear_en_overlap", i), 64'(mac_clear[i] & mac_en[i]), 64'd0);
  endtask

  task automatic send_pair(input int i, input logic [7:0] a, input logic [7:0] b, input int bubble);
    int t;
    s_valid[i] = 1'b1;
    s_a[i]     = a;
    s_b[i]     = b;
    t = 0;
    while (s_ready[i] !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk($sformatf("pe%0d_s_ready_wait", i), 64'(t < 50), 64'd1);
    tick();
    s_valid[i] = 1'b0;
    chk($sformatf("pe%0d_mac_en", i), 64'(mac_en[i]), 64'd1);
    chk($sformatf("pe%0d_mac_a", i), 64'(mac_a[i]), 64'(a));
    chk($sformatf("pe%0d_mac_b", i), 64'(mac_b[i]), 64'(b));
    repeat (bubble) tick();
  endtask

  task automatic get_result(input int i, input int hold, input logic [63:0] exp, input string nm);
    int t;
    t = 0;
    while (res_valid[i] !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    chk({nm, "_res_valid_rise"}, 64'(res_valid[i]), 64'd1);
    chk({nm, "_res_data"}, 64'(res_data[i]), exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({nm, "_hold_valid"}, 64'(res_valid[i]), 64'd1);
      chk({nm, "_hold_s_ready"}, 64'(s_ready[i]), 64'd0);
      chk({nm, "_hold_data"}, 64'(res_data[i]), exp);
    end
    $display("[TB] pe%0d %s result=%0d expected=%0d", i, nm, res_data[i], exp);
    res_ready[i] = 1'b1;
    tick();
    res_ready[i] = 1'b0;
    chk({nm, "_accept_valid_low"}, 64'(res_valid[i]), 64'd0);
    chk({nm, "_clear_after"}, 64'(mac_clear[i]), 64'd1);
    chk({nm, "_busy_low"}, 64'(busy[i]), 64'd0);
    tick();
    chk({nm, "_rearm_s_ready"}, 64'(s_ready[i]), 64'd1);
    chk({nm, "_rearm_clear_low"}, 64'(mac_clear[i]), 64'd0);
  endtask

  task automatic run_random(input int i, input int vl, input int id);
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [63:0] exp;
    for (int k = 0; k < vl; k++) begin
      qa.push_back(8'($urandom_range(0, 255)));
      qb.push_back(8'($urandom_range(0, 255)));
    end
    exp = 64'd0;
    foreach (qa[k]) exp += 64'(qa[k]) * 64'(qb[k]);
    for (int k = 0; k < vl; k++)
      send_pair(i, qa[k], qb[k], (k < vl - 1) ? int'($urandom_range(0, 2)) : 0);
    get_result(i, int'($urandom_range(0, 3)), exp, $sformatf("rand%0d", id));
  endtask

  task automatic check_reset_outputs(input int i);
    chk($sformatf("pe%0d_rst_s_ready", i), 64'(s_ready[i]), 64'd0);
    chk($sformatf("pe%0d_rst_mac_en", i), 64'(mac_en[i]), 64'd0);
    chk($sformatf("pe%0d_rst_res_valid", i), 64'(res_valid[i]), 64'd0);
    chk($sformatf("pe%0d_rst_mac_clear", i), 64'(mac_clear[i]), 64'd0);
    chk($sformatf("pe%0d_rst_mac_a", i), 64'(mac_a[i]), 64'd0);
    chk($sformatf("pe%0d_rst_mac_b", i), 64'(mac_b[i]), 64'd0);
    chk($sformatf("pe%0d_rst_res_data", i), 64'(res_data[i]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl[0].a = {8'd100, 8'd50, 8'd25, 8'd15};
    tbl[0].b = {8'd50, 8'd30, 8'd20, 8'd10};
    tbl[0].bubble = 0; tbl[0].hold = 0; tbl[0].exp = 64'd7150;
    tbl[1].a = {4{8'd255}};
    tbl[1].b = {4{8'd255}};
    tbl[1].bubble = 0; tbl[1].hold = 0; tbl[1].exp = 64'd260100;
    tbl[2].a = {8'd4, 8'd3, 8'd2, 8'd1};
    tbl[2].b = {8'd4, 8'd3, 8'd2, 8'd1};
    tbl[2].bubble = 2; tbl[2].hold = 5; tbl[2].exp = 64'd30;
    tbl[3] = tbl[0];
    tbl[4].a = {4{8'd2}};
    tbl[4].b = {4{8'd3}};
    tbl[4].bubble = 0; tbl[4].hold = 1; tbl[4].exp = 64'd24;

    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      s_valid[i] = 1'b0; s_a[i] = '0; s_b[i] = '0; res_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_reset_outputs(i);

    // First cycle after reset release is the clear cycle.
    reset = 1'b1;
    #1;
    chk("init_clear", 64'(mac_clear[0]), 64'd1);
    chk("init_s_ready", 64'(s_ready[0]), 64'd0);
    chk("init_busy", 64'(busy[0]), 64'd0);
    tick();
    chk("init_clear_done", 64'(mac_clear[0]), 64'd0);
    chk("init_s_ready_up", 64'(s_ready[0]), 64'd1);
    chk("init_busy_up", 64'(busy[0]), 64'd1);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++)
        send_pair(0, tbl[r].a[k], tbl[r].b[k], (k < 3) ? tbl[r].bubble : 0);
      get_result(0, tbl[r].hold, tbl[r].exp, $sformatf("vec%0d", r));
    end

    for (int k = 0; k < 16; k++) send_pair(1, 8'd255, 8'd255, 0);
    get_result(1, 0, 64'd1040400, "full16");

    // VEC_LEN=1 latency with res_ready held high.
    res_ready[2] = 1'b1;
    s_valid[2] = 1'b1; s_a[2] = 8'd7; s_b[2] = 8'd9;
    chk("len1_s_ready", 64'(s_ready[2]), 64'd1);
    tick();
    s_valid[2] = 1'b0;
    chk("len1_mac_en", 64'(mac_en[2]), 64'd1);
    chk("len1_s_ready_drop", 64'(s_ready[2]), 64'd0);
    chk("len1_valid_c1", 64'(res_valid[2]), 64'd0);
    tick();
    chk("len1_valid_c2", 64'(res_valid[2]), 64'd0);
    tick();
    chk("len1_valid_c3", 64'(res_valid[2]), 64'd1);
    chk("len1_res_data", 64'(res_data[2]), 64'd63);
    $display("[TB] pe2 len1 result=%0d expected=63", res_data[2]);
    tick();
    chk("len1_accepted", 64'(res_valid[2]), 64'd0);
    chk("len1_clear", 64'(mac_clear[2]), 64'd1);
    res_ready[2] = 1'b0;
    tick();

    for (int n = 0; n < 6; n++) run_random(0, 4, n);
    for (int n = 0; n < 2; n++) run_random(1, 16, 6 + n);
    for (int n = 0; n < 3; n++) run_random(2, 1, 8 + n);

    // Abort a half-filled vector with reset; only the following vector may report.
    send_pair(0, 8'd9, 8'd9, 0);
    send_pair(0, 8'd9, 8'd9, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs(0);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    tick();
    tick();
    chk("midrst_held_valid", 64'(res_valid[0]), 64'd0);
    reset = 1'b1;
    #1;
    chk("midrst_clear", 64'(mac_clear[0]), 64'd1);
    tick();
    for (int k = 0; k < 4; k++) send_pair(0, 8'd1, 8'd2, 0);
    get_result(0, 0, 64'd8, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
